// File: rtl/pwm_axil_regs.sv
// AXI4-Lite register block for a multi-channel PWM core: shadow registers
// written over the bus, copied to the active outputs on a synchronised commit.

module pwm_axil_shreg #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_resetn,
  input  logic         i_we,
  input  logic [31:0]  i_wdata,
  input  logic [3:0]   i_wstrb,
  input  logic         i_commit,
  output logic [W-1:0] o_shadow,
  output logic [W-1:0] o_active
);
  logic [W-1:0] shadow_q, shadow_d, active_q;
  logic [31:0]  cur, merged;

  always_comb begin
    cur    = 32'(shadow_q);
    merged = cur;
    for (int b = 0; b < 4; b++)
      if (i_wstrb[b]) merged[8*b +: 8] = i_wdata[8*b +: 8];
    shadow_d = i_we ? W'(merged) : shadow_q;
  end

  // Bits above the field width are dropped on write.
  if (W < 32) begin : g_trunc
    logic unused_hi;
    assign unused_hi = ^merged[31:W];
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      if (i_commit) active_q <= shadow_q;
    end
  end

  assign o_shadow = shadow_q;
  assign o_active = active_q;
endmodule

module pwm_axil_regs #(
  parameter int NUM_CHANNELS    = 4,
  parameter int REG_WIDTH       = 16,
  parameter int PRESCALER_WIDTH = 16,
  parameter int ADDR_WIDTH      = 8
) (
  input  logic                              i_clk,
  input  logic                              i_resetn,
  input  logic [ADDR_WIDTH-1:0]             i_awaddr,
  input  logic                              i_awvalid,
  output logic                              o_awready,
  input  logic [31:0]                       i_wdata,
  input  logic [3:0]                        i_wstrb,
  input  logic                              i_wvalid,
  output logic                              o_wready,
  output logic [1:0]                        o_bresp,
  output logic                              o_bvalid,
  input  logic                              i_bready,
  input  logic [ADDR_WIDTH-1:0]             i_araddr,
  input  logic                              i_arvalid,
  output logic                              o_arready,
  output logic [31:0]                       o_rdata,
  output logic [1:0]                        o_rresp,
  output logic                              o_rvalid,
  input  logic                              i_rready,
  input  logic                              i_sync,
  output logic                              o_enable,
  output logic [PRESCALER_WIDTH-1:0]        o_prescale,
  output logic [NUM_CHANNELS*REG_WIDTH-1:0] o_period,
  output logic [NUM_CHANNELS*REG_WIDTH-1:0] o_duty
);
  localparam int         WW          = ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  rdy_q, aw_vld_q, w_vld_q, bvalid_q, rvalid_q;
  logic [WW-1:0]         awidx_q, ridx;
  logic [31:0]           wdata_q, rdata_q, rdata_d;
  logic [3:0]            wstrb_q;
  logic [1:0]            bresp_q, rresp_q, rresp_d;
  logic                  ctrl_en_q, enable_q, pending_q;
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic                  wr_go, wr_ctrl, wr_pre, wr_ok;
  logic [NUM_CHANNELS-1:0] per_we, duty_we;
  logic [PRESCALER_WIDTH-1:0] pre_sh;
  logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0] per_sh, duty_sh;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{i_awaddr[1:0], i_araddr[1:0]};

  // rdy_q holds the ready outputs low until the first edge out of reset.
  assign o_awready = rdy_q & ~aw_vld_q & ~bvalid_q;
  assign o_wready  = rdy_q & ~w_vld_q  & ~bvalid_q;
  assign o_arready = rdy_q & ~rvalid_q;
  assign aw_hs     = i_awvalid & o_awready;
  assign w_hs      = i_wvalid  & o_wready;
  assign ar_hs     = i_arvalid & o_arready;
  assign commit    = pending_q & (i_sync | ~enable_q);

  always_comb begin
    wr_go   = aw_vld_q & w_vld_q;
    wr_ctrl = wr_go && (awidx_q == WW'(0));
    wr_pre  = wr_go && (awidx_q == WW'(1));
    per_we  = '0;
    duty_we = '0;
    for (int n = 0; n < NUM_CHANNELS; n++) begin
      per_we[n]  = wr_go && (awidx_q == WW'(4 + 2*n));
      duty_we[n] = wr_go && (awidx_q == WW'(5 + 2*n));
    end
    wr_ok = wr_ctrl | wr_pre | (|per_we) | (|duty_we);
  end

  always_comb begin
    ridx    = i_araddr[ADDR_WIDTH-1:2];
    rdata_d = '0;
    rresp_d = RESP_OKAY;
    if (ridx == WW'(0))      rdata_d = {31'd0, ctrl_en_q};
    else if (ridx == WW'(1)) rdata_d = 32'(pre_sh);
    else if (ridx == WW'(2)) rdata_d = {31'd0, pending_q};
    else                     rresp_d = RESP_SLVERR;
    for (int n = 0; n < NUM_CHANNELS; n++) begin
      if (ridx == WW'(4 + 2*n)) begin rdata_d = 32'(per_sh[n]);  rresp_d = RESP_OKAY; end
      if (ridx == WW'(5 + 2*n)) begin rdata_d = 32'(duty_sh[n]); rresp_d = RESP_OKAY; end
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      rdy_q     <= 1'b0;
      aw_vld_q  <= 1'b0;
      w_vld_q   <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      ctrl_en_q <= 1'b0;
      enable_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (aw_hs) begin
        aw_vld_q <= 1'b1;
        awidx_q  <= i_awaddr[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_vld_q <= 1'b1;
        wdata_q <= i_wdata;
        wstrb_q <= i_wstrb;
      end
      if (wr_go) begin
        aw_vld_q <= 1'b0;
        w_vld_q  <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (i_bready) begin
        bvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
        rresp_q  <= rresp_d;
      end else if (i_rready) begin
        rvalid_q <= 1'b0;
      end
      if (wr_ctrl && wstrb_q[0]) ctrl_en_q <= wdata_q[0];
      enable_q <= ctrl_en_q;
      // A fresh UPDATE wins over a commit on the same edge so it is not lost.
      if (wr_ctrl && wstrb_q[0] && wdata_q[1]) pending_q <= 1'b1;
      else if (commit)                         pending_q <= 1'b0;
    end
  end

  pwm_axil_shreg #(.W(PRESCALER_WIDTH)) u_pre (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_we(wr_pre), .i_wdata(wdata_q),
    .i_wstrb(wstrb_q), .i_commit(commit), .o_shadow(pre_sh), .o_active(o_prescale)
  );

  pwm_axil_shreg #(.W(REG_WIDTH)) u_per [NUM_CHANNELS-1:0] (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_we(per_we), .i_wdata(wdata_q),
    .i_wstrb(wstrb_q), .i_commit(commit), .o_shadow(per_sh), .o_active(o_period)
  );

  pwm_axil_shreg #(.W(REG_WIDTH)) u_duty [NUM_CHANNELS-1:0] (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_we(duty_we), .i_wdata(wdata_q),
    .i_wstrb(wstrb_q), .i_commit(commit), .o_shadow(duty_sh), .o_active(o_duty)
  );

  assign o_bvalid = bvalid_q;
  assign o_bresp  = bresp_q;
  assign o_rvalid = rvalid_q;
  assign o_rdata  = rdata_q;
  assign o_rresp  = rresp_q;
  assign o_enable = enable_q;
endmodule

// File: tb/tb_pwm_axil_regs.sv
// Bench for pwm_axil_regs: directed vector table, corner-case sequences and
// randomized bus traffic against a register-map model.

module tb_pwm_axil_regs;
  localparam int NCH = 4, RW = 16, PW = 16, AW = 8, TMO = 30;
  localparam logic [31:0] RMASK = (RW == 32) ? 32'hFFFF_FFFF : (32'd1 << RW) - 1;
  localparam logic [31:0] PMASK = (PW == 32) ? 32'hFFFF_FFFF : (32'd1 << PW) - 1;

  logic              i_clk = 1'b0, i_resetn = 1'b0;
  logic [AW-1:0]     i_awaddr = '0, i_araddr = '0;
  logic              i_awvalid = 1'b0, i_wvalid = 1'b0, i_bready = 1'b0;
  logic              i_arvalid = 1'b0, i_rready = 1'b0, i_sync = 1'b1;
  logic [31:0]       i_wdata = '0;
  logic [3:0]        i_wstrb = '0;
  logic              o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_enable;
  logic [1:0]        o_bresp, o_rresp;
  logic [31:0]       o_rdata;
  logic [PW-1:0]     o_prescale;
  logic [NCH*RW-1:0] o_period, o_duty;

  pwm_axil_regs #(.NUM_CHANNELS(NCH), .REG_WIDTH(RW), .PRESCALER_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_resetn(i_resetn),
    .i_awaddr(i_awaddr), .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .i_araddr(i_araddr), .i_arvalid(i_arvalid), .o_arready(o_arready),
    .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rvalid(o_rvalid), .i_rready(i_rready),
    .i_sync(i_sync), .o_enable(o_enable), .o_prescale(o_prescale),
    .o_period(o_period), .o_duty(o_duty)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- register-map model ----------------
  logic [31:0] m_pre, m_pre_act;
  logic [31:0] m_per[NCH], m_duty[NCH], m_per_act[NCH], m_duty_act[NCH];
  logic        m_en, m_pend;

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic m_reset();
    m_pre = 0; m_pre_act = 0; m_en = 0; m_pend = 0;
    for (int c = 0; c < NCH; c++) begin
      m_per[c] = 0; m_duty[c] = 0; m_per_act[c] = 0; m_duty_act[c] = 0;
    end
  endtask

  task automatic m_commit();
    m_pre_act = m_pre;
    for (int c = 0; c < NCH; c++) begin m_per_act[c] = m_per[c]; m_duty_act[c] = m_duty[c]; end
    m_pend = 0;
  endtask

  task automatic m_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    int w = int'(a[7:2]);
    resp = 2'b00;
    if (w == 0) begin
      if (s[0]) begin m_en = d[0]; if (d[1]) m_pend = 1'b1; end
    end else if (w == 1) m_pre = bmerge(m_pre, d, s) & PMASK;
    else if (w >= 4 && w < 4 + 2*NCH) begin
      if (w % 2 == 0) m_per[(w-4)/2]  = bmerge(m_per[(w-4)/2], d, s) & RMASK;
      else            m_duty[(w-5)/2] = bmerge(m_duty[(w-5)/2], d, s) & RMASK;
    end else resp = 2'b10;
  endtask

  task automatic m_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int w = int'(a[7:2]);
    d = 0; resp = 2'b00;
    if (w == 0) d = {31'd0, m_en};
    else if (w == 1) d = m_pre;
    else if (w == 2) d = {31'd0, m_pend};
    else if (w >= 4 && w < 4 + 2*NCH) d = (w % 2 == 0) ? m_per[(w-4)/2] : m_duty[(w-5)/2];
    else resp = 2'b10;
  endtask

  task automatic check_outputs(input string tag);
    logic [NCH*RW-1:0] ep, ed;
    for (int c = 0; c < NCH; c++) begin
      ep[c*RW +: RW] = m_per_act[c][RW-1:0];
      ed[c*RW +: RW] = m_duty_act[c][RW-1:0];
    end
    check({tag, "_enable"}, o_enable, m_en);
    check({tag, "_prescale"}, o_prescale, m_pre_act[PW-1:0]);
    check({tag, "_period"}, o_period, ep);
    check({tag, "_duty"}, o_duty, ed);
  endtask

  // ---------------- bus tasks (called #1 after a rising edge) ----------------
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    int n = 0;
    bit awd = 0, wd = 0, ah, wh;
    i_awaddr = a; i_awvalid = 1; i_wdata = d; i_wstrb = s; i_wvalid = 1; i_bready = 0;
    while (!(awd && wd) && n < TMO) begin
      ah = i_awvalid && o_awready;
      wh = i_wvalid && o_wready;
      @(posedge i_clk); #1; n++;
      if (ah) begin awd = 1; i_awvalid = 0; end
      if (wh) begin wd = 1; i_wvalid = 0; end
    end
    while (!o_bvalid && n < TMO) begin @(posedge i_clk); #1; n++; end
    check("write_completes", n < TMO, 1);
    i_awvalid = 0; i_wvalid = 0;
    resp = o_bresp;
    i_bready = 1; @(posedge i_clk); #1; i_bready = 0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    bit ard = 0, ah;
    i_araddr = a; i_arvalid = 1; i_rready = 0;
    while (!ard && n < TMO) begin
      ah = o_arready;
      @(posedge i_clk); #1; n++;
      if (ah) begin ard = 1; i_arvalid = 0; end
    end
    while (!o_rvalid && n < TMO) begin @(posedge i_clk); #1; n++; end
    check("read_completes", n < TMO, 1);
    i_arvalid = 0;
    d = o_rdata; resp = o_rresp;
    i_rready = 1; @(posedge i_clk); #1; i_rready = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_enable"}, o_enable, 0);
    check({tag, "_bvalid"}, o_bvalid, 0);
    check({tag, "_rvalid"}, o_rvalid, 0);
    check({tag, "_readys"}, {o_awready, o_wready, o_arready}, 3'b000);
    check({tag, "_rdata"}, o_rdata, 0);
    check({tag, "_resps"}, {o_bresp, o_rresp}, 4'b0000);
    check({tag, "_active"}, {o_prescale, o_period, o_duty} != 0, 0);
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t        vt[13];
    logic [1:0]  resp, eresp;
    logic [31:0] rd, erd, old;
    logic [7:0]  alist[14];
    int          n;

    vt[0]  = '{8'h04, 32'h12345678, 4'b0011, 2'b00, 32'h00005678, 2'b00};
    vt[1]  = '{8'h04, 32'hAABBCCDD, 4'b1000, 2'b00, 32'h00005678, 2'b00};
    vt[2]  = '{8'h04, 32'h0000FFFF, 4'b0000, 2'b00, 32'h00005678, 2'b00};
    vt[3]  = '{8'h10, 32'hDEAD1234, 4'b1111, 2'b00, 32'h00001234, 2'b00};
    vt[4]  = '{8'h17, 32'h0000ABCD, 4'b1111, 2'b00, 32'h0000ABCD, 2'b00};
    vt[5]  = '{8'h0C, 32'hFFFFFFFF, 4'b1111, 2'b10, 32'h00000000, 2'b10};
    vt[6]  = '{8'hF0, 32'hFFFFFFFF, 4'b1111, 2'b10, 32'h00000000, 2'b10};
    vt[7]  = '{8'h08, 32'h00000001, 4'b1111, 2'b10, 32'h00000000, 2'b00};
    vt[8]  = '{8'h2C, 32'h00000077, 4'b0001, 2'b00, 32'h00000077, 2'b00};
    vt[9]  = '{8'h30, 32'hFFFFFFFF, 4'b1111, 2'b10, 32'h00000000, 2'b10};
    vt[10] = '{8'h18, 32'h00FF0042, 4'b0101, 2'b00, 32'h00000042, 2'b00};
    vt[11] = '{8'h00, 32'h00000000, 4'b1111, 2'b00, 32'h00000000, 2'b00};
    vt[12] = '{8'h04, 32'h00000000, 4'b0100, 2'b00, 32'h00005678, 2'b00};
    alist = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
              8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'hF0};
    m_reset();

    // Reset state and ready release
    repeat (2) @(posedge i_clk);
    #1 check_reset_outputs("reset");
    i_resetn = 1;
    check("ready_before_edge", {o_awready, o_wready, o_arready}, 3'b000);
    @(posedge i_clk); #1;
    check("ready_after_edge", {o_awready, o_wready, o_arready}, 3'b111);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      axi_write(vt[i].addr, vt[i].wdata, vt[i].strb, resp);
      m_write(vt[i].addr, vt[i].wdata, vt[i].strb, eresp);
      check($sformatf("vec%0d_bresp", i), resp, vt[i].bresp);
      axi_read(vt[i].addr, rd, resp);
      check($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
      check($sformatf("vec%0d_rresp", i), resp, vt[i].rresp);
    end
    check("no_commit_without_update", {o_prescale, o_period, o_duty} != 0, 0);

    // UPDATE with ENABLE=0 commits at once
    axi_write(8'h18, 32'd1000, 4'hF, resp);
    m_write(8'h18, 32'd1000, 4'hF, eresp);
    axi_write(8'h00, 32'h2, 4'hF, resp);
    m_write(8'h00, 32'h2, 4'hF, eresp);
    m_commit();
    check("upd_bresp", resp, 2'b00);
    check("upd_period1", o_period[31:16], 16'd1000);
    check_outputs("upd");
    axi_read(8'h08, rd, resp);
    check("upd_status", rd, 0);

    // ENABLE lands on o_enable one cycle after the register write
    i_awaddr = 8'h00; i_wdata = 32'h1; i_wstrb = 4'hF;
    i_awvalid = 1; i_wvalid = 1; i_bready = 1;
    @(posedge i_clk); #1; i_awvalid = 0; i_wvalid = 0;
    check("en_latched", o_enable, 0);
    @(posedge i_clk); #1;
    check("en_write_edge", {o_bvalid, o_enable}, 2'b10);
    @(posedge i_clk); #1; i_bready = 0;
    check("en_next_edge", o_enable, 1);
    m_write(8'h00, 32'h1, 4'hF, eresp);

    // Commit held off by i_sync while enabled
    i_sync = 0;
    axi_write(8'h14, 32'd500, 4'hF, resp);
    m_write(8'h14, 32'd500, 4'hF, eresp);
    axi_write(8'h00, 32'h3, 4'hF, resp);
    m_write(8'h00, 32'h3, 4'hF, eresp);
    repeat (20) @(posedge i_clk);
    #1 check_outputs("sync_hold");
    axi_read(8'h08, rd, resp);
    check("sync_hold_status", rd, 1);
    i_sync = 1;
    @(posedge i_clk); #1; i_sync = 0;
    m_commit();
    check("sync_duty0", o_duty[15:0], 16'd500);
    check_outputs("sync_commit");
    axi_read(8'h08, rd, resp);
    check("sync_status", rd, 0);

    // W leads AW by 3 cycles, B back-pressured for 5 cycles
    i_awaddr = 8'h04; i_wdata = 32'h00004321; i_wstrb = 4'hF; i_bready = 0;
    i_wvalid = 1;
    @(posedge i_clk); #1;
    check("wfirst_w_latched", o_wready, 0);
    repeat (2) @(posedge i_clk);
    #1 i_awvalid = 1;
    n = 0;
    while (!o_bvalid && n < TMO) begin @(posedge i_clk); #1; n++; end
    check("wfirst_bvalid", n < TMO, 1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bhold%0d", k), {o_bvalid, o_bresp, o_awready, o_wready}, 5'b10000);
      @(posedge i_clk); #1;
    end
    i_awvalid = 0; i_wvalid = 0; i_bready = 1;
    @(posedge i_clk); #1; i_bready = 0;
    m_write(8'h04, 32'h00004321, 4'hF, eresp);
    check("bhold_released", o_bvalid, 0);
    repeat (3) @(posedge i_clk);
    #1 check("no_second_b", o_bvalid, 0);
    axi_read(8'h04, rd, resp);
    check("wfirst_readback", rd, 32'h4321);

    // Read accepted on the write edge sees the old value
    m_read(8'h04, old, eresp);
    i_awaddr = 8'h04; i_wdata = 32'h00000BEE; i_wstrb = 4'hF;
    i_awvalid = 1; i_wvalid = 1;
    @(posedge i_clk); #1; i_awvalid = 0; i_wvalid = 0;
    i_araddr = 8'h04; i_arvalid = 1;
    check("rw_arready", o_arready, 1);
    @(posedge i_clk); #1; i_arvalid = 0;
    check("rw_both_valid", {o_bvalid, o_rvalid}, 2'b11);
    check("rw_old_value", o_rdata, old);
    i_rready = 1; i_bready = 1;
    @(posedge i_clk); #1; i_rready = 0; i_bready = 0;
    m_write(8'h04, 32'h00000BEE, 4'hF, eresp);
    axi_read(8'h04, rd, resp);
    check("rw_new_value", rd, 32'h0BEE);

    // Reset with a read response outstanding and a commit pending
    axi_write(8'h00, 32'h3, 4'hF, resp);
    i_araddr = 8'h08; i_arvalid = 1;
    @(posedge i_clk); #1; i_arvalid = 0;
    check("rst_pre_rvalid", {o_rvalid, o_rdata[0]}, 2'b11);
    #2 i_resetn = 0;
    #1 check_reset_outputs("midreset");
    m_reset();
    @(posedge i_clk); #1;
    check("midreset_ready_held", {o_awready, o_wready, o_arready}, 3'b000);
    i_resetn = 1;
    @(posedge i_clk); #1;
    check("midreset_ready_back", {o_awready, o_wready, o_arready}, 3'b111);
    axi_read(8'h08, rd, resp);
    check("midreset_status", rd, 0);

    // Randomized traffic, immediate commit
    i_sync = 1;
    for (int i = 0; i < 60; i++) begin
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      a = alist[$urandom_range(0, 13)] | 8'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, resp);
        m_write(a, d, s, eresp);
        if (m_pend) m_commit();
        check($sformatf("rnd%0d_bresp", i), resp, eresp);
        check_outputs($sformatf("rnd%0d", i));
      end else begin
        axi_read(a, rd, resp);
        m_read(a, erd, eresp);
        check($sformatf("rnd%0d_rdata", i), rd, erd);
        check($sformatf("rnd%0d_rresp", i), resp, eresp);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
